// File: rtl/riscv_lsu_pkg.sv
// Shared types and constants for the load/store unit.
// funct3 codes, latched request context and align results.
package riscv_lsu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] LSU_F3_B  = 3'b000;
  localparam logic [2:0] LSU_F3_H  = 3'b001;
  localparam logic [2:0] LSU_F3_W  = 3'b010;
  localparam logic [2:0] LSU_F3_BU = 3'b100;
  localparam logic [2:0] LSU_F3_HU = 3'b101;

  typedef struct packed {
    logic       we;
    logic [2:0] funct3;
    logic [1:0] addr_lo;
  } lsu_ctx_t;

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational lane steering, byte enables, load extension
// and misalign/illegal checks. In: we,funct3,addr_lo,wdata,rdata.
module riscv_lsu_align
  import riscv_lsu_pkg::*;
(
  input  logic            we,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] st_data,
  output logic [XLEN-1:0] ld_data,
  output logic            misalign,
  output logic            illegal
);

  logic            is_b;
  logic            is_h;
  logic            is_w;
  logic [XLEN-1:0] shifted;

  assign is_b = (funct3[1:0] == 2'b00);
  assign is_h = (funct3[1:0] == 2'b01);
  assign is_w = (funct3[1:0] == 2'b10);

  // Stores only take 000/001/010; loads add the unsigned 100/101.
  always_comb begin
    illegal = 1'b0;
    if (we)
      illegal = funct3[2] | (funct3[1:0] == 2'b11);
    else
      illegal = (funct3 == 3'b011) | (funct3[2:1] == 2'b11);
  end

  assign misalign = (is_h & addr_lo[0])
                  | (is_w & (addr_lo != 2'b00));

  always_comb begin
    be      = 4'b1111;
    st_data = wdata;
    unique case (1'b1)
      is_b: begin
        be      = 4'b0001 << addr_lo;
        st_data = {4{wdata[7:0]}};
      end
      is_h: begin
        be      = 4'b0011 << addr_lo;
        st_data = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign shifted = rdata >> {addr_lo, 3'b000};

  always_comb begin
    ld_data = shifted;
    unique case (funct3)
      LSU_F3_B:
        ld_data = {{24{shifted[7]}}, shifted[7:0]};
      LSU_F3_H:
        ld_data = {{16{shifted[15]}}, shifted[15:0]};
      LSU_F3_BU:
        ld_data = {24'd0, shifted[7:0]};
      LSU_F3_HU:
        ld_data = {16'd0, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// RV32I load/store unit: single-outstanding req/gnt/rvalid port.
// EX side: valid/ready/we/funct3/addr/wdata; WB: done/err/rdata.
module riscv_lsu
  import riscv_lsu_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_lsu_valid,
  output logic            o_lsu_ready,
  input  logic            i_lsu_we,
  input  logic [2:0]      i_lsu_funct3,
  input  logic [XLEN-1:0] i_lsu_addr,
  input  logic [XLEN-1:0] i_lsu_wdata,
  output logic            o_lsu_done,
  output logic            o_lsu_err,
  output logic [XLEN-1:0] o_lsu_rdata,
  output logic            o_dmem_req,
  input  logic            i_dmem_gnt,
  output logic            o_dmem_we,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic [XLEN-1:0] o_dmem_wdata,
  output logic [3:0]      o_dmem_be,
  input  logic            i_dmem_rvalid,
  input  logic [XLEN-1:0] i_dmem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nx;
  lsu_ctx_t        ctx_q;
  logic            idle;
  logic            accept;
  logic            bad;
  logic            a_we;
  logic [2:0]      a_f3;
  logic [1:0]      a_lo;
  logic [3:0]      a_be;
  logic [XLEN-1:0] a_st;
  logic [XLEN-1:0] a_ld;
  logic            a_mis;
  logic            a_ill;

  assign idle   = (state == S_IDLE);
  assign accept = idle & i_lsu_valid;
  assign bad    = a_mis | a_ill;

  // Idle decodes the incoming request; later states
  // reuse the aligner on the latched context for loads.
  assign a_we = idle ? i_lsu_we         : ctx_q.we;
  assign a_f3 = idle ? i_lsu_funct3     : ctx_q.funct3;
  assign a_lo = idle ? i_lsu_addr[1:0]  : ctx_q.addr_lo;

  riscv_lsu_align u_align (
    .we       (a_we),
    .funct3   (a_f3),
    .addr_lo  (a_lo),
    .wdata    (i_lsu_wdata),
    .rdata    (i_dmem_rdata),
    .be       (a_be),
    .st_data  (a_st),
    .ld_data  (a_ld),
    .misalign (a_mis),
    .illegal  (a_ill)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (i_lsu_valid)
          state_nx = bad ? S_DONE : S_REQ;
      S_REQ:
        if (i_dmem_gnt)
          state_nx = ctx_q.we ? S_DONE : S_WAIT;
      S_WAIT:
        if (i_dmem_rvalid)
          state_nx = S_DONE;
      S_DONE:
        state_nx = S_IDLE;
      default:
        state_nx = S_IDLE;
    endcase
  end

  assign o_lsu_ready = idle;
  assign o_lsu_done  = (state == S_DONE);
  assign o_dmem_req  = (state == S_REQ);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ctx_q        <= '0;
      o_lsu_err    <= 1'b0;
      o_lsu_rdata  <= '0;
      o_dmem_we    <= 1'b0;
      o_dmem_addr  <= '0;
      o_dmem_wdata <= '0;
      o_dmem_be    <= 4'b0000;
    end else begin
      if (accept) begin
        ctx_q.we      <= i_lsu_we;
        ctx_q.funct3  <= i_lsu_funct3;
        ctx_q.addr_lo <= i_lsu_addr[1:0];
        o_lsu_err     <= bad;
      end
      // Faulting accesses leave the memory port untouched.
      if (accept && !bad) begin
        o_dmem_we    <= i_lsu_we;
        o_dmem_addr  <= {i_lsu_addr[XLEN-1:2], 2'b00};
        o_dmem_wdata <= a_st;
        o_dmem_be    <= a_be;
      end
      if (state == S_WAIT && i_dmem_rvalid)
        o_lsu_rdata <= a_ld;
    end
  end

endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Load/store unit of the RV32I core, directly downstream of the ALU: takes the ALU result as the effective address, plus rs2 and funct3 from EX. It drives a single-outstanding request/grant/rvalid data-memory port and returns sign- or zero-extended load data to writeback. It performs byte-lane steering, byte-enable generation, misalignment detection and illegal-funct3 detection, and raises a one-cycle completion pulse per access.

## Interface
- `XLEN`, 32 (from riscv_configs.v): datapath width; block is defined for 32 only.
- i_clk  in  1  core clock, rising edge.
- i_rstn  in  1  asynchronous active-low reset.
- i_lsu_valid  in  1  access request from EX; sampled only when o_lsu_ready=1.
- o_lsu_ready  out  1  LSU idle, accepts a request this cycle.
- i_lsu_we  in  1  1=store, 0=load.
- i_lsu_funct3  in  3  RV32I funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
- i_lsu_addr  in  XLEN  effective address (ALU result).
- i_lsu_wdata  in  XLEN  store data (rs2).
- o_lsu_done  out  1  one-cycle completion pulse.
- o_lsu_err  out  1  valid with o_lsu_done: misaligned address or illegal funct3.
- o_lsu_rdata  out  XLEN  extended load result, valid with o_lsu_done on loads.
- o_dmem_req  out  1  memory request.
- i_dmem_gnt  in  1  request accepted.
- o_dmem_we  out  1  write strobe.
- o_dmem_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00}).
- o_dmem_wdata  out  XLEN  lane-replicated store data.
- o_dmem_be  out  4  byte enables.
- i_dmem_rvalid  in  1  read data valid.
- i_dmem_rdata  in  XLEN  read word.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: o_lsu_ready=1. On i_lsu_valid, latch we/funct3/addr/wdata.
  - If the access is illegal or misaligned, go to DONE with err=1. No memory access is made.
  - Otherwise go to REQ.
- REQ: o_dmem_req=1. All o_dmem_* outputs are held stable until i_dmem_gnt.
  - On gnt with a store: go to DONE.
  - On gnt with a load: go to WAIT.
- WAIT: on i_dmem_rvalid, capture the extracted load data into o_lsu_rdata and go to DONE. rvalid is never accepted in the gnt cycle; it arrives at the earliest one cycle later.
- DONE: o_lsu_done=1 for exactly one cycle, then IDLE.
- Illegal funct3:
  - loads: 011, 110, 111.
  - stores: anything other than 000/001/010.
- Misaligned:
  - halfword (LH/LHU/SH) with addr[0]=1.
  - word (LW/SW) with addr[1:0]≠0.
  - Byte accesses are never misaligned.
- Byte enables:
  - byte access: 4'b0001<<addr[1:0].
  - halfword: 4'b0011<<addr[1:0].
  - word: 4'b1111.
  - Loads drive the same pattern.
- Store data:
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata.
- Load extract:
  - word = i_dmem_rdata >> (8*addr[1:0]).
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes through.
- o_lsu_rdata holds its value until the next successful load. Stores and errored accesses do not change it.
- i_dmem_rvalid outside WAIT is ignored.
- i_dmem_gnt outside REQ is ignored.

## Timing
- Reset values:
  - state IDLE.
  - o_lsu_ready=1 (decoded from IDLE); EX must not assert valid while i_rstn=0.
  - o_lsu_done=0, o_lsu_err=0, o_lsu_rdata=0.
  - o_dmem_req=0, o_dmem_we=0, o_dmem_addr=0, o_dmem_wdata=0, o_dmem_be=0.
- All outputs are registered or decoded directly from state. There is no combinational path from dmem inputs to dmem outputs.
- Latency, with accept at cycle N:
  - error access: done at N+1.
  - store, gnt at N+1: done at N+2.
  - load, gnt at N+1, rvalid at N+2: done at N+3.
  - Each gnt/rvalid stall cycle adds one cycle.
- Back-to-back: ready returns the cycle after DONE, so minimum issue spacing is 3 cycles (store) or 4 cycles (load).
- Reset mid-operation: an asynchronous return to IDLE with all outputs at reset values. A later rvalid for the abandoned load is ignored.

## Structure
- riscv_configs.v gains the funct3 constants `LSU_F3_B/H/W/BU/HU`.
- FSM state encodings stay local localparams.
- Sub-module riscv_lsu_align (combinational):
  - inputs: funct3, addr[1:0], wdata, rdata.
  - outputs: be, steered wdata, extended rdata, misalign/illegal flags.
- riscv_lsu contains the FSM and registers.

## Test plan
- SW addr 0x100, wdata 0xDEADBEEF, gnt immediate → req at N+1 with be=1111, addr 0x100, wdata 0xDEADBEEF; done at N+2, err=0.
- SB addr 0x103, wdata 0x000000A5 → be=1000, dmem_wdata 0xA5A5A5A5, addr 0x100.
- LB addr 0x101, rdata 0x1234_80FF → rdata_out 0xFFFFFF80. LBU, same inputs → 0x00000080. LHU addr 0x102 → 0x00001234.
- LW addr 0x102 → done at N+1, err=1, req never asserted, o_lsu_rdata unchanged. Load funct3=011 → err=1.
- LH with gnt delayed 3 cycles and rvalid delayed 2 → req and addr stable throughout; done exactly once; rdata correct.
- i_rstn pulsed low while in WAIT → immediate IDLE with req=0; a subsequent rvalid produces no done pulse.
